// File: rtl/passcode_lock_ctrl_if.sv
// Keypad-side strobes and lock/display status of the passcode lock controller.
// The keypad encoder side is the master; the controller is the slave.
interface passcode_lock_ctrl_if;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_clr;
   logic       prog_req;
   logic       alarm_clr;
   logic       unlocked;
   logic       alarm;
   logic       code_set;
   logic [3:0] attempts;
   logic [3:0] digit_count;
   logic [3:0] disp_digit;
   logic [2:0] state;

   modport master (
      output key_valid, key_digit, key_clr, prog_req, alarm_clr,
      input  unlocked, alarm, code_set, attempts, digit_count, disp_digit, state
   );

   modport slave (
      input  key_valid, key_digit, key_clr, prog_req, alarm_clr,
      output unlocked, alarm, code_set, attempts, digit_count, disp_digit, state
   );
endinterface

// File: rtl/passcode_lock_ctrl.sv
// Passcode lock sequencer: programs a DIGITS-long BCD code, captures entries,
// compares them, counts failed attempts and drives unlock/alarm/display outputs.
module passcode_lock_ctrl #(
   parameter int DIGITS        = 8,
   parameter int MAX_ATTEMPTS  = 5,
   parameter int UNLOCK_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   passcode_lock_ctrl_if.slave  bus
);
   localparam int                 CODE_W     = DIGITS * 4;
   localparam int                 TIMER_W    = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
   localparam logic [3:0]         LAST_DIGIT = 4'(DIGITS - 1);
   localparam logic [3:0]         MAX_ATT    = 4'(MAX_ATTEMPTS);
   localparam logic [TIMER_W-1:0] LAST_OPEN  = TIMER_W'(UNLOCK_CYCLES - 1);
   localparam logic [3:0]         BLANK      = 4'hF;

   typedef enum logic [2:0] {
      PROG  = 3'd0,
      ENTRY = 3'd1,
      CHECK = 3'd2,
      OPEN  = 3'd3,
      ALARM = 3'd4
   } state_t;

   state_t             state_q;
   logic [CODE_W-1:0]  stored_q;
   logic [CODE_W-1:0]  entry_q;
   logic               code_set_q;
   logic               unlocked_q;
   logic               alarm_q;
   logic [3:0]         attempts_q;
   logic [3:0]         count_q;
   logic [3:0]         disp_q;
   logic [TIMER_W-1:0] open_timer_q;

   logic digit_ok;
   logic last_digit;

   // Non-BCD codes (10-15) from the encoder are treated as no key at all.
   assign digit_ok   = bus.key_valid && (bus.key_digit <= 4'd9);
   assign last_digit = (count_q == LAST_DIGIT);

   // NOTE: every state update below uses <= so all branches read pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ENTRY;
         stored_q     <= '0;
         entry_q      <= '0;
         code_set_q   <= 1'b0;
         unlocked_q   <= 1'b0;
         alarm_q      <= 1'b0;
         attempts_q   <= '0;
         count_q      <= '0;
         disp_q       <= BLANK;
         open_timer_q <= '0;
      end else begin
         case (state_q)
            PROG: begin
               // A repeated prog_req simply restarts programming, like key_clr.
               if (bus.prog_req || bus.key_clr) begin
                  count_q <= '0;
                  disp_q  <= BLANK;
               end else if (digit_ok) begin
                  stored_q <= {stored_q[CODE_W-5:0], bus.key_digit};
                  disp_q   <= bus.key_digit;
                  if (last_digit) begin
                     code_set_q <= 1'b1;
                     attempts_q <= '0;
                     count_q    <= '0;
                     state_q    <= ENTRY;
                  end else begin
                     count_q <= count_q + 4'd1;
                  end
               end
            end

            ENTRY: begin
               if (bus.prog_req && !code_set_q) begin
                  count_q <= '0;
                  disp_q  <= BLANK;
                  state_q <= PROG;
               end else if (bus.key_clr) begin
                  entry_q <= '0;
                  count_q <= '0;
                  disp_q  <= BLANK;
               end else if (digit_ok && code_set_q) begin
                  entry_q <= {entry_q[CODE_W-5:0], bus.key_digit};
                  disp_q  <= bus.key_digit;
                  count_q <= count_q + 4'd1;
                  if (last_digit) begin
                     state_q <= CHECK;
                  end
               end
            end

            CHECK: begin
               entry_q <= '0;
               count_q <= '0;
               if (entry_q == stored_q) begin
                  attempts_q   <= '0;
                  unlocked_q   <= 1'b1;
                  open_timer_q <= '0;
                  state_q      <= OPEN;
               end else if (attempts_q + 4'd1 == MAX_ATT) begin
                  attempts_q <= MAX_ATT;
                  alarm_q    <= 1'b1;
                  state_q    <= ALARM;
               end else begin
                  attempts_q <= attempts_q + 4'd1;
                  state_q    <= ENTRY;
               end
            end

            OPEN: begin
               if (bus.prog_req) begin
                  unlocked_q <= 1'b0;
                  count_q    <= '0;
                  disp_q     <= BLANK;
                  state_q    <= PROG;
               end else if (open_timer_q == LAST_OPEN) begin
                  unlocked_q <= 1'b0;
                  state_q    <= ENTRY;
               end else begin
                  open_timer_q <= open_timer_q + TIMER_W'(1);
               end
            end

            ALARM: begin
               if (bus.alarm_clr) begin
                  attempts_q <= '0;
                  alarm_q    <= 1'b0;
                  state_q    <= ENTRY;
               end
            end

            default: state_q <= ENTRY;
         endcase
      end
   end

   assign bus.state       = state_q;
   assign bus.unlocked    = unlocked_q;
   assign bus.alarm       = alarm_q;
   assign bus.code_set    = code_set_q;
   assign bus.attempts    = attempts_q;
   assign bus.digit_count = count_q;
   assign bus.disp_digit  = disp_q;
endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Scenario bench for passcode_lock_ctrl: each task queues stimulus steps with the
// expected output snapshot after selected edges and compares as outputs appear.
module tb_passcode_lock_ctrl;
   localparam logic [2:0]  S_PROG   = 3'd0;
   localparam logic [2:0]  S_ENTRY  = 3'd1;
   localparam logic [2:0]  S_CHECK  = 3'd2;
   localparam logic [2:0]  S_OPEN   = 3'd3;
   localparam logic [2:0]  S_ALARM  = 3'd4;
   localparam logic [3:0]  BLANK    = 4'hF;
   localparam logic [31:0] CODE_A   = 32'h2193_5488;
   localparam logic [31:0] CODE_BAD = 32'h2193_5487;
   localparam logic [31:0] CODE_B   = 32'h0000_0001;

   typedef struct {
      logic        rst;
      logic        kv;
      logic [3:0]  kd;
      logic        kc;
      logic        pr;
      logic        ac;
      logic        chk;
      logic [17:0] exp;
   } step_t;

   logic clk = 1'b0;
   logic rst;

   step_t       seq[$];
   logic [17:0] sb[$];
   int          n_checks = 0;
   int          n_fails  = 0;

   passcode_lock_ctrl_if bus ();

   passcode_lock_ctrl #(
      .DIGITS       (8),
      .MAX_ATTEMPTS (5),
      .UNLOCK_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [17:0] ev(input logic [2:0] st, input logic unl, input logic alm,
                                      input logic cs, input logic [3:0] att,
                                      input logic [3:0] cnt, input logic [3:0] disp);
      return {st, unl, alm, cs, att, cnt, disp};
   endfunction

   function automatic logic [17:0] outs();
      return {bus.state, bus.unlocked, bus.alarm, bus.code_set,
              bus.attempts, bus.digit_count, bus.disp_digit};
   endfunction

   function automatic string fmt(input logic [17:0] v);
      return $sformatf("state=%0d unlocked=%b alarm=%b code_set=%b attempts=%0d digit_count=%0d disp_digit=%h",
                       v[17:15], v[14], v[13], v[12], v[11:8], v[7:4], v[3:0]);
   endfunction

   // Stimulus builders: append one clock of inputs to seq.
   task automatic add(input logic r, input logic kv, input logic [3:0] kd,
                      input logic kc, input logic pr, input logic ac);
      step_t s;
      s.rst = r; s.kv = kv; s.kd = kd; s.kc = kc; s.pr = pr; s.ac = ac;
      s.chk = 1'b0; s.exp = '0;
      seq.push_back(s);
   endtask

   task automatic add_rst();                  add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
   task automatic add_idle();                 add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
   task automatic add_key(input logic [3:0] d); add(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0); endtask
   task automatic add_clr();                  add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
   task automatic add_prog();                 add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
   task automatic add_aclr();                 add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask

   task automatic add_code(input logic [31:0] c);
      for (int i = 0; i < 8; i++) add_key(c[31-4*i -: 4]);
   endtask

   task automatic add_program(input logic [31:0] c);
      add_prog();
      add_code(c);
   endtask

   task automatic expect_last(input logic [17:0] e);
      seq[seq.size()-1].chk = 1'b1;
      seq[seq.size()-1].exp = e;
   endtask

   // Drive one clock at the negedge; outputs are read at the following negedge.
   task automatic drive(input step_t s);
      rst = s.rst;
      bus.key_valid = s.kv; bus.key_digit = s.kd; bus.key_clr = s.kc;
      bus.prog_req = s.pr;  bus.alarm_clr = s.ac;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.key_valid = 1'b0; bus.key_digit = 4'd0; bus.key_clr = 1'b0;
      bus.prog_req = 1'b0;  bus.alarm_clr = 1'b0;
   endtask

   task automatic test_reset();
      logic [17:0] exp_v, got_v;
      seq.delete();
      add_rst();     expect_last(ev(S_ENTRY, 0, 0, 0, 4'd0, 4'd0, BLANK));
      add_idle();    expect_last(ev(S_ENTRY, 0, 0, 0, 4'd0, 4'd0, BLANK));
      add_key(4'd5); expect_last(ev(S_ENTRY, 0, 0, 0, 4'd0, 4'd0, BLANK));
      foreach (seq[i]) begin
         if (seq[i].chk) sb.push_back(seq[i].exp);
         drive(seq[i]);
         if (seq[i].chk) begin
            exp_v = sb.pop_front();
            got_v = outs();
            n_checks++;
            if (got_v !== exp_v) begin
               n_fails++;
               $display("FAIL reset step %0d: got %s required %s", i, fmt(got_v), fmt(exp_v));
            end
         end
      end
   endtask

   task automatic test_program_enter();
      logic [17:0] exp_v, got_v;
      seq.delete();
      add_rst();
      add_prog();    expect_last(ev(S_PROG, 0, 0, 0, 4'd0, 4'd0, BLANK));
      add_key(4'd2); expect_last(ev(S_PROG, 0, 0, 0, 4'd0, 4'd1, 4'd2));
      add_key(4'd1); add_key(4'd9); add_key(4'd3); add_key(4'd5); add_key(4'd4);
      add_key(4'd8); expect_last(ev(S_PROG, 0, 0, 0, 4'd0, 4'd7, 4'd8));
      add_key(4'd8); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd0, 4'd8));
      add_key(4'd2); add_key(4'd1);
      add_key(4'd9); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd3, 4'd9));
      add_key(4'd3); add_key(4'd5); add_key(4'd4);
      add_key(4'd8); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd7, 4'd8));
      add_key(4'd8); expect_last(ev(S_CHECK, 0, 0, 1, 4'd0, 4'd8, 4'd8));
      add_idle();    expect_last(ev(S_OPEN, 1, 0, 1, 4'd0, 4'd0, 4'd8));
      for (int k = 0; k < 15; k++) add_idle();
      expect_last(ev(S_OPEN, 1, 0, 1, 4'd0, 4'd0, 4'd8));
      add_idle();    expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd0, 4'd8));
      foreach (seq[i]) begin
         if (seq[i].chk) sb.push_back(seq[i].exp);
         drive(seq[i]);
         if (seq[i].chk) begin
            exp_v = sb.pop_front();
            got_v = outs();
            n_checks++;
            if (got_v !== exp_v) begin
               n_fails++;
               $display("FAIL prog_enter step %0d: got %s required %s", i, fmt(got_v), fmt(exp_v));
            end
         end
      end
   endtask

   task automatic test_wrong_entries();
      logic [17:0] exp_v, got_v;
      seq.delete();
      add_rst();
      add_program(CODE_A);
      for (int a = 1; a <= 4; a++) begin
         add_code(CODE_BAD);
         add_idle(); expect_last(ev(S_ENTRY, 0, 0, 1, 4'(a), 4'd0, 4'd7));
      end
      add_code(CODE_BAD); expect_last(ev(S_CHECK, 0, 0, 1, 4'd4, 4'd8, 4'd7));
      add_idle();    expect_last(ev(S_ALARM, 0, 1, 1, 4'd5, 4'd0, 4'd7));
      add_key(4'd3); expect_last(ev(S_ALARM, 0, 1, 1, 4'd5, 4'd0, 4'd7));
      add_clr();
      add_prog();    expect_last(ev(S_ALARM, 0, 1, 1, 4'd5, 4'd0, 4'd7));
      add_aclr();    expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd0, 4'd7));
      add_key(4'd2); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd1, 4'd2));
      add_key(4'd1); add_key(4'd9); add_key(4'd3); add_key(4'd5); add_key(4'd4); add_key(4'd8);
      add_key(4'd8); expect_last(ev(S_CHECK, 0, 0, 1, 4'd0, 4'd8, 4'd8));
      add_idle();    expect_last(ev(S_OPEN, 1, 0, 1, 4'd0, 4'd0, 4'd8));
      foreach (seq[i]) begin
         if (seq[i].chk) sb.push_back(seq[i].exp);
         drive(seq[i]);
         if (seq[i].chk) begin
            exp_v = sb.pop_front();
            got_v = outs();
            n_checks++;
            if (got_v !== exp_v) begin
               n_fails++;
               $display("FAIL wrong_entries step %0d: got %s required %s", i, fmt(got_v), fmt(exp_v));
            end
         end
      end
   endtask

   task automatic test_clear_invalid();
      logic [17:0] exp_v, got_v;
      seq.delete();
      add_rst();
      add_program(CODE_A);
      add_code(CODE_BAD);
      add_idle();    expect_last(ev(S_ENTRY, 0, 0, 1, 4'd1, 4'd0, 4'd7));
      add_key(4'd2); add_key(4'd1); add_key(4'd9);
      add_key(4'd3); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd1, 4'd4, 4'd3));
      add_clr();     expect_last(ev(S_ENTRY, 0, 0, 1, 4'd1, 4'd0, BLANK));
      add_key(4'hB); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd1, 4'd0, BLANK));
      add_key(4'd2); add_key(4'd1);
      add_key(4'hB); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd1, 4'd2, 4'd1));
      add_key(4'd9); add_key(4'd3); add_key(4'd5); add_key(4'd4); add_key(4'd8);
      add_key(4'd8); expect_last(ev(S_CHECK, 0, 0, 1, 4'd1, 4'd8, 4'd8));
      add_idle();    expect_last(ev(S_OPEN, 1, 0, 1, 4'd0, 4'd0, 4'd8));
      foreach (seq[i]) begin
         if (seq[i].chk) sb.push_back(seq[i].exp);
         drive(seq[i]);
         if (seq[i].chk) begin
            exp_v = sb.pop_front();
            got_v = outs();
            n_checks++;
            if (got_v !== exp_v) begin
               n_fails++;
               $display("FAIL clear_invalid step %0d: got %s required %s", i, fmt(got_v), fmt(exp_v));
            end
         end
      end
   endtask

   task automatic test_priority();
      logic [17:0] exp_v, got_v;
      seq.delete();
      add_rst();
      add_key(4'd2);
      add_key(4'd1); expect_last(ev(S_ENTRY, 0, 0, 0, 4'd0, 4'd0, BLANK));
      add_program(CODE_A); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd0, 4'd8));
      add_key(4'd2); add_key(4'd1);
      add(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
      expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd0, BLANK));
      // prog_req is ignored once a code exists, so the digit goes through.
      add(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
      expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd1, 4'd2));
      add_key(4'd1); add_key(4'd9); add_key(4'd3); add_key(4'd5); add_key(4'd4); add_key(4'd8);
      add_key(4'd8); expect_last(ev(S_CHECK, 0, 0, 1, 4'd0, 4'd8, 4'd8));
      add_idle();
      add_key(4'd5); expect_last(ev(S_OPEN, 1, 0, 1, 4'd0, 4'd0, 4'd8));
      add(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
      expect_last(ev(S_PROG, 0, 0, 1, 4'd0, 4'd0, BLANK));
      add_aclr();    expect_last(ev(S_PROG, 0, 0, 1, 4'd0, 4'd0, BLANK));
      foreach (seq[i]) begin
         if (seq[i].chk) sb.push_back(seq[i].exp);
         drive(seq[i]);
         if (seq[i].chk) begin
            exp_v = sb.pop_front();
            got_v = outs();
            n_checks++;
            if (got_v !== exp_v) begin
               n_fails++;
               $display("FAIL priority step %0d: got %s required %s", i, fmt(got_v), fmt(exp_v));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [17:0] exp_v, got_v;
      seq.delete();
      add_rst();
      add_program(CODE_A);
      add_key(4'd2); add_key(4'd1); add_key(4'd9); add_key(4'd3);
      add_key(4'd5); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd5, 4'd5));
      add_rst();     expect_last(ev(S_ENTRY, 0, 0, 0, 4'd0, 4'd0, BLANK));
      add_prog();    expect_last(ev(S_PROG, 0, 0, 0, 4'd0, 4'd0, BLANK));
      add_key(4'd4);
      add_rst();     expect_last(ev(S_ENTRY, 0, 0, 0, 4'd0, 4'd0, BLANK));
      add_program(CODE_A);
      add_code(CODE_A);
      add_idle();    expect_last(ev(S_OPEN, 1, 0, 1, 4'd0, 4'd0, 4'd8));
      add_rst();     expect_last(ev(S_ENTRY, 0, 0, 0, 4'd0, 4'd0, BLANK));
      add_program(CODE_A);
      for (int a = 0; a < 5; a++) begin
         add_code(CODE_BAD);
         add_idle();
      end
      expect_last(ev(S_ALARM, 0, 1, 1, 4'd5, 4'd0, 4'd7));
      add_rst();     expect_last(ev(S_ENTRY, 0, 0, 0, 4'd0, 4'd0, BLANK));
      foreach (seq[i]) begin
         if (seq[i].chk) sb.push_back(seq[i].exp);
         drive(seq[i]);
         if (seq[i].chk) begin
            exp_v = sb.pop_front();
            got_v = outs();
            n_checks++;
            if (got_v !== exp_v) begin
               n_fails++;
               $display("FAIL reset_mid step %0d: got %s required %s", i, fmt(got_v), fmt(exp_v));
            end
         end
      end
   endtask

   task automatic test_reprogram();
      logic [17:0] exp_v, got_v;
      seq.delete();
      add_rst();
      add_program(CODE_A);
      add_code(CODE_A);
      add_idle();    expect_last(ev(S_OPEN, 1, 0, 1, 4'd0, 4'd0, 4'd8));
      add_prog();    expect_last(ev(S_PROG, 0, 0, 1, 4'd0, 4'd0, BLANK));
      add_key(4'd9);
      add_key(4'd9); expect_last(ev(S_PROG, 0, 0, 1, 4'd0, 4'd2, 4'd9));
      add_clr();     expect_last(ev(S_PROG, 0, 0, 1, 4'd0, 4'd0, BLANK));
      add_code(CODE_B); expect_last(ev(S_ENTRY, 0, 0, 1, 4'd0, 4'd0, 4'd1));
      add_code(CODE_A);
      add_idle();    expect_last(ev(S_ENTRY, 0, 0, 1, 4'd1, 4'd0, 4'd8));
      add_code(CODE_B);
      add_idle();    expect_last(ev(S_OPEN, 1, 0, 1, 4'd0, 4'd0, 4'd1));
      foreach (seq[i]) begin
         if (seq[i].chk) sb.push_back(seq[i].exp);
         drive(seq[i]);
         if (seq[i].chk) begin
            exp_v = sb.pop_front();
            got_v = outs();
            n_checks++;
            if (got_v !== exp_v) begin
               n_fails++;
               $display("FAIL reprogram step %0d: got %s required %s", i, fmt(got_v), fmt(exp_v));
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.key_valid = 1'b0; bus.key_digit = 4'd0; bus.key_clr = 1'b0;
      bus.prog_req = 1'b0;  bus.alarm_clr = 1'b0;
      @(negedge clk);
      test_reset();
      test_program_enter();
      test_wrong_entries();
      test_clear_invalid();
      test_priority();
      test_reset_mid();
      test_reprogram();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
